// File: rtl/mmss_countdown_timer.sv
// BCD MM:SS countdown core: keypad digit entry, run/pause/clear control and a one-cycle done pulse.
// Optional +1 minute strobe (add_min port) is built only when MMSS_ADD_MINUTE_EN is defined.
module mmss_countdown_timer #(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV   = 4
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  input  logic                    start,
  input  logic                    stop,
`ifdef MMSS_ADD_MINUTE_EN
  input  logic                    add_min,
`endif
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    running,
  output logic                    paused,
  output logic                    zero,
  output logic                    done
);

  localparam int unsigned NumDigits = MIN_DIGITS + 2;
  localparam int unsigned TimeW     = 4 * NumDigits;
  localparam int unsigned PrescW    = $clog2(TICK_DIV);

  localparam logic [PrescW-1:0] PrescMax  = PrescW'(TICK_DIV - 1);
  localparam logic [TimeW-1:0]  OneMinute = TimeW'(1) << 8;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e             state_q, state_d;
  logic [TimeW-1:0]   time_q, time_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic               done_q, done_d;
  logic               add_req;
  logic               tick;
  logic [TimeW-1:0]   run_time;

`ifdef MMSS_ADD_MINUTE_EN
  assign add_req = add_min;
`else
  assign add_req = 1'b0;
`endif

  // Digit 1 (seconds tens) borrows to 5; every other digit borrows to 9.
  function automatic logic [TimeW-1:0] dec_time(input logic [TimeW-1:0] t);
    logic       borrow;
    logic [3:0] dg;
    dec_time = t;
    borrow   = 1'b1;
    for (int i = 0; i < int'(NumDigits); i++) begin
      dg = t[4*i +: 4];
      if (borrow) begin
        if (dg == 4'd0) begin
          dg = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          dg     = dg - 4'd1;
          borrow = 1'b0;
        end
      end
      dec_time[4*i +: 4] = dg;
    end
  endfunction

  // +1 minute in BCD; saturates when every minute digit is already 9.
  function automatic logic [TimeW-1:0] add_minute(input logic [TimeW-1:0] t);
    logic       sat;
    logic       carry;
    logic [3:0] dg;
    add_minute = t;
    sat        = 1'b1;
    for (int i = 2; i < int'(NumDigits); i++) begin
      if (t[4*i +: 4] != 4'd9) sat = 1'b0;
    end
    if (!sat) begin
      carry = 1'b1;
      for (int i = 2; i < int'(NumDigits); i++) begin
        dg = t[4*i +: 4];
        if (carry) begin
          if (dg == 4'd9) begin
            dg = 4'd0;
          end else begin
            dg    = dg + 4'd1;
            carry = 1'b0;
          end
        end
        add_minute[4*i +: 4] = dg;
      end
    end
  endfunction

  assign zero = (time_q == '0);
  assign tick = (presc_q == PrescMax);

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    run_time = time_q;
    unique case (state_q)
      StIdle: begin
        if (stop) begin
          time_d = '0;
        end else if (start) begin
          if (!zero) begin
            state_d = StRun;
            presc_d = '0;
          end
        end else if (add_req) begin
          if (zero) begin
            time_d  = OneMinute;
            state_d = StRun;
            presc_d = '0;
          end else begin
            time_d = add_minute(time_q);
          end
        end else if (digit_valid && (digit_in <= 4'd9)) begin
          time_d = {time_q[TimeW-5:0], digit_in};
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else begin
          if (tick) begin
            presc_d  = '0;
            run_time = dec_time(time_q);
          end else begin
            presc_d  = presc_q + PrescW'(1);
          end
          // A concurrent start is ignored but still masks the lower-priority add.
          if (add_req && !start) run_time = add_minute(run_time);
          time_d = run_time;
          if (tick && (run_time == '0)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
          time_d  = '0;
        end else if (start) begin
          state_d = StRun;
        end else if (add_req) begin
          time_d = add_minute(time_q);
        end
      end
      StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StDone;
        end else if (add_req) begin
          time_d  = OneMinute;
          state_d = StRun;
          presc_d = '0;
        end else if (digit_valid && (digit_in <= 4'd9)) begin
          state_d = StIdle;
          time_d  = TimeW'(digit_in);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      time_q  <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign sec_ones = time_q[3:0];
  assign sec_tens = time_q[7:4];
  assign mins     = time_q[TimeW-1:8];
  assign running  = (state_q == StRun);
  assign paused   = (state_q == StPause);
  assign done     = done_q;

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Bench for mmss_countdown_timer: directed scenarios plus random strobes, checked each cycle
// against an arithmetic minutes/seconds reference model through an expectation queue.
module tb_mmss_countdown_timer;

  localparam int unsigned MD = 1;
  localparam int unsigned TD = 4;
  localparam int          VW = 4 * MD + 12;
`ifdef MMSS_ADD_MINUTE_EN
  localparam bit AddEn = 1'b1;
`else
  localparam bit AddEn = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t;

  logic          clock = 1'b0;
  logic          clear;
  logic [3:0]    digit_in;
  logic          digit_valid, start, stop;
`ifdef MMSS_ADD_MINUTE_EN
  logic          add_min;
`endif
  logic [3:0]    sec_ones, sec_tens;
  logic [4*MD-1:0] mins;
  logic          running, paused, zero, done;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];

  // Reference model: 0 idle, 1 run, 2 pause, 3 done; time kept as integer minutes and seconds.
  int m_state, m_min, m_sec, m_presc;
  bit m_done;

  mmss_countdown_timer #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
    .clock(clock), .clear(clear), .digit_in(digit_in), .digit_valid(digit_valid),
    .start(start), .stop(stop),
`ifdef MMSS_ADD_MINUTE_EN
    .add_min(add_min),
`endif
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .running(running),
    .paused(paused), .zero(zero), .done(done)
  );

  always #5 clock = ~clock;

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic vec_t expected();
    logic [4*MD-1:0] mv;
    for (int i = 0; i < int'(MD); i++) mv[4*i +: 4] = 4'((m_min / pow10(i)) % 10);
    return {mv, 4'(m_sec / 10), 4'(m_sec % 10), m_state == 1, m_state == 2,
            (m_min == 0) && (m_sec == 0), m_done};
  endfunction

  function automatic vec_t observed();
    return {mins, sec_tens, sec_ones, running, paused, zero, done};
  endfunction

  task automatic model_reset();
    m_state = 0; m_min = 0; m_sec = 0; m_presc = 0; m_done = 1'b0;
  endtask

  task automatic model_shift(input int d);
    int total;
    total = ((m_min * 100 + m_sec) * 10 + d) % pow10(MD + 2);
    m_min = total / 100;
    m_sec = total % 100;
  endtask

  task automatic model_step(input bit stp, input bit sta, input bit dv, input int d,
                            input bit ad);
    int maxmin;
    bit z, tk;
    maxmin = pow10(MD) - 1;
    z      = (m_min == 0) && (m_sec == 0);
    m_done = 1'b0;
    case (m_state)
      0: begin
        if (stp) begin
          m_min = 0; m_sec = 0;
        end else if (sta) begin
          if (!z) begin m_state = 1; m_presc = 0; end
        end else if (ad) begin
          if (z) begin m_min = 1; m_sec = 0; m_state = 1; m_presc = 0; end
          else if (m_min < maxmin) m_min++;
        end else if (dv && d <= 9) begin
          model_shift(d);
        end
      end
      1: begin
        if (stp) begin
          m_state = 2;
        end else begin
          tk      = (m_presc == TD - 1);
          m_presc = tk ? 0 : m_presc + 1;
          if (tk) begin
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
          end
          if (ad && !sta && m_min < maxmin) m_min++;
          if (tk && m_min == 0 && m_sec == 0) begin m_state = 3; m_done = 1'b1; end
        end
      end
      2: begin
        if (stp) begin m_state = 0; m_min = 0; m_sec = 0; end
        else if (sta) m_state = 1;
        else if (ad && m_min < maxmin) m_min++;
      end
      default: begin
        if (stp) m_state = 0;
        else if (sta) m_state = 3;
        else if (ad) begin m_min = 1; m_sec = 0; m_state = 1; m_presc = 0; end
        else if (dv && d <= 9) begin m_state = 0; m_min = 0; m_sec = d; end
      end
    endcase
  endtask

  task automatic cyc(input bit stp, input bit sta, input bit dv, input logic [3:0] d,
                     input bit ad);
    @(negedge clock);
    clear       = 1'b1;
    stop        = stp;
    start       = sta;
    digit_valid = dv;
    digit_in    = d;
`ifdef MMSS_ADD_MINUTE_EN
    add_min     = ad;
`endif
    model_step(stp, sta, dv, int'(d), ad && AddEn);
    exp_q.push_back(expected());
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0; stop = 1'b0; start = 1'b0; digit_valid = 1'b0;
`ifdef MMSS_ADD_MINUTE_EN
    add_min = 1'b0;
`endif
    model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare one queued expectation per edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t got={mins,tens,ones,run,pause,zero,done}=%h want=%h",
                   $time, observed(), e);
        end
      end
    end
  end

  initial begin
    bit stp, sta, dv, ad;
    logic [3:0] d;
    clear = 1'b0; stop = 1'b0; start = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
`ifdef MMSS_ADD_MINUTE_EN
    add_min = 1'b0;
`endif
    model_reset();
    #3;
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", observed(), expected());
    end

    // Digit entry with an out-of-range digit and leading-digit drop.
    key(4'd1); key(4'd3); key(4'd0); key(4'hA); key(4'd5);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // 1:00 down to 0:00 and the done pulse.
    key(4'd1); key(4'd0); key(4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(60 * TD + 4);

    // From DONE: digit entry returns to idle; 0:90 runs 90 ticks; start at zero ignored.
    key(4'd0); key(4'd9); key(4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(90 * TD + 3);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    key(4'd5);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(6);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

    // Pause/resume at 0:45 with the prescaler held mid-count.
    key(4'd4); key(4'd5);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(6);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(20);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(9);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // Reset while running.
    key(4'd2); key(4'd3); key(4'd4);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(7);
    do_reset();
    idle(3);

    if (AddEn) begin
      key(4'd9); key(4'd3); key(4'd0);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      idle(5);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    end

    // Random strobes; stop is rare so that some runs reach zero.
    repeat (20000) begin
      if ($urandom_range(0, 2999) == 0) begin
        do_reset();
      end else begin
        stp = ($urandom_range(0, 59) == 0);
        sta = ($urandom_range(0, 11) == 0);
        dv  = ($urandom_range(0, 4) == 0);
        d   = 4'($urandom_range(0, 15));
        ad  = AddEn && ($urandom_range(0, 39) == 0);
        cyc(stp, sta, dv, d, ad);
      end
    end
    idle(2);

    @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
